chess_cursor_ctrl: RTL
======================

Name: chess_cursor_ctrl

Overview:
- Upstream input stage for the board LCD renderer. Six raw push-buttons are synchronised, debounced and edge-detected.
- Maintains the 6-bit cursor (row in [5:3], col in [2:0]; row 7 is drawn at the top) and the enter/esc status the renderer uses for highlighting.
- Runs a select-source / select-destination state machine that hands completed moves to the move engine over a valid/ready handshake.
- Single clock domain: clk12.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronised cycles before a button state is accepted (10 ms at 12 MHz); minimum 1.
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CURSOR_INIT, 6'b100_100, cursor value after reset.
- WRAP, 1, 1 = cursor wraps 7<->0 at board edges; 0 = cursor saturates at 0/7.

Ports:
- clk12  input  1  system clock, 12 MHz.
- reset  input  1  reset, synchronous, active-high; clock clk12.
- btn_up  input  1  raw button, async, active-high: row+1.
- btn_down  input  1  raw button: row-1.
- btn_left  input  1  raw button: col-1.
- btn_right  input  1  raw button: col+1.
- btn_enter  input  1  raw button: select / confirm.
- btn_esc  input  1  raw button: cancel.
- cursor  output  6  current square {row, col}.
- enter_pressed  output  1  level; high while a source square is latched (states SELECTED and PENDING).
- esc_pressed  output  1  one-cycle pulse on every accepted esc edge.
- move_src  output  6  latched source square.
- move_dst  output  6  latched destination square.
- move_valid  output  1  move offered to the downstream engine.
- move_ready  input  1  downstream accepts the move.

Behaviour:
- Reset values:
  - cursor=CURSOR_INIT; enter_pressed=0; esc_pressed=0; move_valid=0; move_src=0; move_dst=0.
  - All synchronisers, stable-state registers and debounce counters cleared; state=IDLE.
  - Reset mid-operation (including mid-handshake) discards any latched source or pending move.
- Input conditioning, per button:
  - Two-flop synchroniser.
  - Counter clears whenever the sync output equals the stable state, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable state flips and the counter clears.
  - Rising edge of the stable state gives a one-cycle internal pulse. Falling edges produce nothing.
- Latency:
  - Raw rise held from before edge 0: the cursor/state update is visible after edge DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no pulse.
  - Holding a button gives exactly one pulse. There is no auto-repeat.
- Cursor update (states IDLE and SELECTED only; pulses in PENDING are dropped):
  - Row and col are updated independently in the same cycle.
  - up and down together: no row change. left and right together: no col change.
  - WRAP=1: 7+1 -> 0 and 0-1 -> 7 (3-bit modulo). WRAP=0: saturate at 7 and at 0.
- State machine, registered, one transition per cycle:
  - IDLE:
    - esc -> esc_pressed pulse, stay in IDLE.
    - enter (no esc) -> move_src=cursor, enter_pressed=1, go to SELECTED.
  - SELECTED:
    - esc -> esc_pressed pulse, enter_pressed=0, go to IDLE. esc wins if enter arrives in the same cycle.
    - enter with cursor==move_src -> deselect: enter_pressed=0, go to IDLE, no move.
    - enter with cursor!=move_src -> move_dst=cursor, move_valid=1, go to PENDING.
    - Enter uses the cursor value from before any same-cycle direction update.
  - PENDING:
    - move_valid held high; move_src/move_dst held stable; enter_pressed stays 1.
    - On a cycle with move_valid&move_ready: next cycle move_valid=0, enter_pressed=0, state=IDLE.
    - enter, esc and direction pulses are ignored, and esc_pressed is not asserted.
    - move_ready while not in PENDING is ignored.
- move_src and move_dst change only on the transitions above.

Test Plan:
- DEBOUNCE_CYCLES=4, CURSOR_INIT=6'b100_100. Apply reset, then hold btn_up -> cursor=6'b101_100 after the 7th edge from rise; no further change while held; release, press again -> 6'b110_100.
- btn_right pulsed 2 cycles then low (bounce) -> no cursor change. WRAP=1 with col=7, press right -> col=0. WRAP=0 with row=0, press down -> row stays 0.
- IDLE at 6'b001_100: enter -> enter_pressed=1, move_src=6'b001_100. up, up -> cursor 6'b011_100. enter -> move_valid=1, move_dst=6'b011_100. Hold move_ready=0 for 5 cycles and press left -> all outputs stable, cursor unchanged. move_ready=1 -> one cycle later move_valid=0, enter_pressed=0.
- SELECTED: enter and esc debounced in the same cycle -> esc_pressed pulse of exactly 1 cycle, enter_pressed=0, move_valid stays 0.
- SELECTED, press enter on the source square -> enter_pressed=0, move_valid never asserts. Pressing up and down together -> row unchanged.
- PENDING with move_valid=1, assert reset -> next cycle move_valid=0, enter_pressed=0, cursor=CURSOR_INIT.

Source files
------------

// File: rtl/chess_cursor_ctrl.sv
// Six-button conditioning (sync, debounce, rise detect), board cursor and select-source/destination FSM.
// Completed moves are held on move_valid until move_ready; input pulses arriving meanwhile are dropped.
module chess_cursor_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17,
  parameter logic [5:0]  CURSOR_INIT     = 6'b100_100,
  parameter bit          WRAP            = 1'b1
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  input  logic       btn_esc,
  output logic [5:0] cursor,
  output logic       enter_pressed,
  output logic       esc_pressed,
  output logic [5:0] move_src,
  output logic [5:0] move_dst,
  output logic       move_valid,
  input  logic       move_ready
);

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_ENTER = 4;
  localparam int B_ESC   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECTED, S_PENDING} state_t;

  logic [5:0]       w_raw;
  logic [5:0]       r_sync1, r_sync2, r_stable, r_stable_d, r_pulse;
  logic [CNT_W-1:0] r_cnt [6];

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cursor, w_cursor_nxt;
  logic [5:0] r_src, w_src_nxt;
  logic [5:0] r_dst, w_dst_nxt;
  logic       r_esc, w_esc_nxt;

  assign w_raw = {btn_esc, btn_enter, btn_right, btn_left, btn_down, btn_up};

  // Pulse is registered so every button reaches the FSM with the same fixed latency.
  always_ff @(posedge clk12) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_pulse    <= '0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  function automatic logic [2:0] step3(input logic [2:0] v, input logic inc, input logic dec);
    logic [2:0] r;
    r = v;
    if (inc && !dec)      r = (v == 3'd7 && !WRAP) ? v : v + 3'd1;
    else if (dec && !inc) r = (v == 3'd0 && !WRAP) ? v : v - 3'd1;
    return r;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_esc_nxt    = 1'b0;
    if (r_state != S_PENDING) begin
      w_cursor_nxt = {step3(r_cursor[5:3], r_pulse[B_UP], r_pulse[B_DOWN]),
                      step3(r_cursor[2:0], r_pulse[B_RIGHT], r_pulse[B_LEFT])};
    end
    // Enter latches r_cursor, i.e. the square before any same-cycle move.
    case (r_state)
      S_IDLE: begin
        if (r_pulse[B_ESC]) begin
          w_esc_nxt = 1'b1;
        end else if (r_pulse[B_ENTER]) begin
          w_src_nxt   = r_cursor;
          w_state_nxt = S_SELECTED;
        end
      end
      S_SELECTED: begin
        if (r_pulse[B_ESC]) begin
          w_esc_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_pulse[B_ENTER]) begin
          if (r_cursor == r_src) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_dst_nxt   = r_cursor;
            w_state_nxt = S_PENDING;
          end
        end
      end
      S_PENDING: begin
        if (move_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cursor <= CURSOR_INIT;
      r_src    <= '0;
      r_dst    <= '0;
      r_esc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cursor <= w_cursor_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_esc    <= w_esc_nxt;
    end
  end

  assign cursor        = r_cursor;
  assign enter_pressed = (r_state != S_IDLE);
  assign esc_pressed   = r_esc;
  assign move_src      = r_src;
  assign move_dst      = r_dst;
  assign move_valid    = (r_state == S_PENDING);

endmodule
